// File: rtl/filter_post.sv
// Output stage behind the filter core: decimate, round, shift and saturate the
// 32-bit unsigned filter result, then buffer it in a small FWFT FIFO with a
// valid/ready handshake toward the consumer. Sticky flags report saturation and
// samples lost to a full FIFO.
module filter_post #(
    parameter int unsigned DECIM = 4,
    parameter int unsigned SHIFT = 8,
    parameter int unsigned OUT_W = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              din,
    input  logic                     din_valid,
    output logic [OUT_W-1:0]         dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     sat_flag,
    output logic                     drop_flag,
    input  logic                     clr_flags
);

    localparam int unsigned CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned LW    = AW + 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);
    localparam logic [LW-1:0]    LVL_FULL = LW'(DEPTH);
    // Half an output LSB, so the shift rounds to nearest instead of truncating.
    localparam logic [32:0]      RND      = (SHIFT == 0) ? 33'd0 : (33'd1 << (SHIFT - 1));

    // ------------------------------------------------------------------
    // Decimation counter
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             keep;

    // Count valid inputs and flag the last one of every DECIM as kept.
    always_comb begin
        cnt_d = cnt_q;
        keep  = 1'b0;
        if (din_valid) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                keep  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Decimation counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: round and shift (33-bit so the rounding add never wraps)
    // ------------------------------------------------------------------
    logic [32:0] rnd_sum;
    logic [32:0] shifted;
    logic [32:0] s1_q, s1_d;
    logic        s1_valid_q;

    // Rounding add and shift of the incoming sample.
    always_comb begin
        rnd_sum = {1'b0, din} + RND;
        shifted = rnd_sum >> SHIFT;
        s1_d    = keep ? shifted : s1_q;
    end

    // Stage 1 register; data only loads on a kept sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q       <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            s1_q       <= s1_d;
            s1_valid_q <= keep;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: saturate to OUT_W bits
    // ------------------------------------------------------------------
    logic             s1_sat;
    logic [OUT_W-1:0] s1_clip;
    logic [OUT_W-1:0] s2_q, s2_d;
    logic             s2_valid_q;
    logic             sat_evt;

    // Anything above bit OUT_W-1 means the value does not fit.
    always_comb begin
        s1_sat  = |s1_q[32:OUT_W];
        s1_clip = s1_sat ? {OUT_W{1'b1}} : s1_q[OUT_W-1:0];
        s2_d    = s1_valid_q ? s1_clip : s2_q;
        sat_evt = s1_valid_q & s1_sat;
    end

    // Stage 2 register feeding the FIFO write port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_q       <= '0;
            s2_valid_q <= 1'b0;
        end else begin
            s2_q       <= s2_d;
            s2_valid_q <= s1_valid_q;
        end
    end

    // ------------------------------------------------------------------
    // FWFT output FIFO
    // ------------------------------------------------------------------
    logic [OUT_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    rd_next;
    logic [LW-1:0]    level_q, level_d;
    logic [OUT_W-1:0] head_q, head_d;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             push;
    logic             drop_evt;

    // Handshake decode; a full FIFO still accepts a write when it pops on the same edge.
    always_comb begin
        fifo_full  = (level_q == LVL_FULL);
        fifo_empty = (level_q == '0);
        pop        = ~fifo_empty & dout_ready;
        push       = s2_valid_q & (~fifo_full | pop);
        drop_evt   = s2_valid_q & fifo_full & ~pop;
        rd_next    = rd_ptr_q + 1'b1;
    end

    // Pointer, level and head-of-queue next state.
    always_comb begin
        wr_ptr_d = push ? (wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_next : rd_ptr_q;

        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        // The head register keeps dout stable, including while the FIFO is empty.
        head_d = head_q;
        if (pop) begin
            if (level_q > LW'(1)) begin
                head_d = mem_q[rd_next];
            end else if (push) begin
                head_d = s2_q;
            end
        end else if (push && fifo_empty) begin
            head_d = s2_q;
        end
    end

    // FIFO storage; cleared on reset so stale data never reaches dout.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= s2_q;
        end
    end

    // FIFO control state and head register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            head_q   <= head_d;
        end
    end

    // ------------------------------------------------------------------
    // Sticky flags
    // ------------------------------------------------------------------
    logic sat_q, sat_d;
    logic drop_q, drop_d;

    // A new event in the same cycle as clr_flags keeps the flag set.
    always_comb begin
        sat_d  = sat_evt | (sat_q & ~clr_flags);
        drop_d = drop_evt | (drop_q & ~clr_flags);
    end

    // Flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sat_q  <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            sat_q  <= sat_d;
            drop_q <= drop_d;
        end
    end

    assign dout       = head_q;
    assign dout_valid = ~fifo_empty;
    assign fifo_level = level_q;
    assign sat_flag   = sat_q;
    assign drop_flag  = drop_q;

endmodule

// File: tb/tb_filter_post.sv
// Self-checking bench for filter_post: a queue-based behavioural model is
// compared against the DUT on every falling edge, plus directed scenarios with
// hand-computed expectations.
module tb_filter_post;

    localparam int unsigned DECIM = 4;
    localparam int unsigned SHIFT = 8;
    localparam int unsigned OUT_W = 16;
    localparam int unsigned DEPTH = 4;
    localparam longint      OMAX  = (longint'(1) << OUT_W) - 1;
    localparam longint      RND   = (SHIFT == 0) ? 0 : (longint'(1) << (SHIFT - 1));

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic [31:0]            din = '0;
    logic                   din_valid = 1'b0;
    logic [OUT_W-1:0]       dout;
    logic                   dout_valid;
    logic                   dout_ready = 1'b0;
    logic [$clog2(DEPTH):0] fifo_level;
    logic                   sat_flag;
    logic                   drop_flag;
    logic                   clr_flags = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    filter_post #(
        .DECIM(DECIM),
        .SHIFT(SHIFT),
        .OUT_W(OUT_W),
        .DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .fifo_level(fifo_level),
        .sat_flag  (sat_flag),
        .drop_flag (drop_flag),
        .clr_flags (clr_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: output queue plus a two-deep list of samples in flight.
    // ------------------------------------------------------------------
    longint m_q[$];
    int     m_vcnt;
    bit     m_sat, m_drop;
    bit     p1_v, p2_v;
    longint p1_val, p2_val;

    task automatic model_step();
        bit     do_pop, was_full, sat_ev, drop_ev;
        do_pop   = (m_q.size() > 0) && dout_ready;
        was_full = (m_q.size() == int'(DEPTH));
        sat_ev   = 0;
        drop_ev  = 0;
        if (do_pop) m_q.delete(0);
        if (p2_v) begin
            if (!was_full || do_pop) m_q.push_back(p2_val);
            else drop_ev = 1;
        end
        p2_v = p1_v;
        if (p1_v) begin
            if (p1_val > OMAX) begin
                p2_val = OMAX;
                sat_ev = 1;
            end else begin
                p2_val = p1_val;
            end
        end
        m_sat  = sat_ev ? 1'b1 : (clr_flags ? 1'b0 : m_sat);
        m_drop = drop_ev ? 1'b1 : (clr_flags ? 1'b0 : m_drop);
        p1_v = 0;
        if (din_valid) begin
            m_vcnt++;
            if (m_vcnt == int'(DECIM)) begin
                m_vcnt = 0;
                p1_v   = 1;
                p1_val = (longint'(din) + RND) >>> SHIFT;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_q.delete();
                m_vcnt = 0;
                m_sat  = 0;
                m_drop = 0;
                p1_v   = 0;
                p2_v   = 0;
            end else begin
                model_step();
            end
        end
    end

    // Compare DUT against the model away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("m_dout_valid", longint'(dout_valid), longint'(m_q.size() != 0));
                chk("m_fifo_level", longint'(fifo_level), longint'(m_q.size()));
                chk("m_sat_flag", longint'(sat_flag), longint'(m_sat));
                chk("m_drop_flag", longint'(drop_flag), longint'(m_drop));
                if (dout_valid && m_q.size() != 0) chk("m_dout", longint'(dout), m_q[0]);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    function automatic logic [31:0] rand_din();
        logic [31:0] edges [4];
        edges[0] = 32'h00FF_FF7F;  // rounds to exactly the max code
        edges[1] = 32'h00FF_FF80;  // rounds one past the max code
        edges[2] = 32'hFFFF_FFFF;
        edges[3] = 32'h0000_007F;  // rounds down to zero
        case ($urandom_range(0, 3))
            0:       return edges[$urandom_range(0, 3)];
            1:       return $urandom;
            default: return $urandom & 32'h00FF_FFFF;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Release reset between edges, then expect dout_valid exactly 2 edges after
    // the edge that samples the 4th valid input.
    task automatic release_and_check_latency(input string nm, input bit rnd);
        din_valid  = 1'b1;
        dout_ready = 1'b1;
        reset      = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            if (rnd) din = rand_din();
            tick();
            chk(nm, longint'(dout_valid), longint'(i == 6));
        end
    endtask

    task automatic pulse_reset(input int cycles);
        #2;
        reset = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        bit found;
        int idx;

        // Reset state
        #1;
        chk("rst_dout", longint'(dout), 0);
        chk("rst_valid", longint'(dout_valid), 0);
        chk("rst_level", longint'(fifo_level), 0);
        chk("rst_sat", longint'(sat_flag), 0);
        chk("rst_drop", longint'(drop_flag), 0);
        repeat (3) @(posedge clk);
        #1;

        // 1: constant 0x1280 -> 0x0013, latency and rate
        din = 32'h0000_1280;
        release_and_check_latency("t1_latency", 1'b0);
        chk("t1_first_dout", longint'(dout), 64'h13);
        idx = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (dout_valid) idx++;
        end
        chk("t1_rate", idx, 4);

        // 2: saturation and flag clear
        din   = 32'hFFFF_FFFF;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (dout_valid && dout == 16'hFFFF) found = 1;
        end
        chk("t2_sat_dout", longint'(found), 1);
        chk("t2_sat_flag", longint'(sat_flag), 1);
        din_valid = 1'b0;
        repeat (6) tick();
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        chk("t2_sat_clr", longint'(sat_flag), 0);

        // 3: ramp k<<8 -> 4, 8, 12, 16
        pulse_reset(2);
        reset      = 1'b1;
        din_valid  = 1'b1;
        dout_ready = 1'b1;
        idx        = 0;
        for (int k = 1; k <= 24; k++) begin
            din = 32'(k) << 8;
            tick();
            if (dout_valid && idx < 4) begin
                chk("t3_seq", longint'(dout), longint'(4 * (idx + 1)));
                idx++;
            end
        end
        chk("t3_count", idx, 4);

        // 4: consumer stalled -> full, drop; then drain in order
        dout_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            din = $urandom & 32'h00FF_FFFF;
            tick();
        end
        chk("t4_level_full", longint'(fifo_level), 4);
        chk("t4_drop_flag", longint'(drop_flag), 1);
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        repeat (8) tick();
        chk("t4_drained", longint'(fifo_level), 0);
        din_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            din = rand_din();
            tick();
        end
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;

        // 5: full FIFO with write and pop on the same edge
        pulse_reset(2);
        reset = 1'b1;
        for (int n = 1; n <= 24; n++) begin
            din        = $urandom & 32'h00FF_FFFF;
            din_valid  = (n <= 16) || (n >= 19 && n <= 22);
            dout_ready = (n == 24);
            tick();
            if (n == 23) chk("t5_level_pre", longint'(fifo_level), 4);
        end
        dout_ready = 1'b0;
        din_valid  = 1'b0;
        chk("t5_level_post", longint'(fifo_level), 4);
        chk("t5_no_drop", longint'(drop_flag), 0);
        dout_ready = 1'b1;
        repeat (6) tick();

        // 6: asynchronous reset mid-stream
        din_valid  = 1'b1;
        dout_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            din = rand_din();
            tick();
        end
        chk("t6_pre_level", longint'(fifo_level != 0), 1);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("t6_async_valid", longint'(dout_valid), 0);
        chk("t6_async_level", longint'(fifo_level), 0);
        repeat (3) @(posedge clk);
        #1;
        release_and_check_latency("t6_latency", 1'b1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            din        = rand_din();
            din_valid  = ($urandom_range(0, 3) != 0);
            dout_ready = ($urandom_range(0, 9) < 6);
            clr_flags  = ($urandom_range(0, 19) == 0);
            tick();
        end
        clr_flags = 1'b0;
        din_valid = 1'b0;
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
